// File: rtl/ucaspian_neuron.sv
// Neuron core: per-neuron saturating potential accumulate, strict threshold fire, clear sweeps.
// Three cycles from flush acceptance to fire_vld; a pending fire blocks new flushes until fire_rdy.
module ucaspian_neuron #(
    parameter int NUM_NEURONS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear_act,
    input  logic                     clear_config,
    output logic                     clear_done,
    input  logic                     next_step,
    output logic                     step_done,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [7:0]               cfg_threshold,
    input  logic                     cfg_wr,
    input  logic [ADDR_W-1:0]        dend_addr,
    input  logic signed [15:0]       dend_charge,
    input  logic                     dend_vld,
    output logic                     dend_rdy,
    output logic [ADDR_W-1:0]        fire_addr,
    output logic                     fire_vld,
    input  logic                     fire_rdy
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        UPDATE,
        EMIT,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t state, state_nxt;

    logic signed [15:0] pot_mem [NUM_NEURONS];
    logic [7:0]         thr_mem [NUM_NEURONS];

    logic [ADDR_W-1:0]  addr_q;
    logic signed [15:0] charge_q;
    logic signed [15:0] pot_rd;
    logic [7:0]         thr_rd;

    logic [ADDR_W-1:0]  sweep_idx;
    logic               sweep_cfg;
    logic               sweep_fin;

    logic               clear_any;
    logic               accept;
    logic signed [16:0] sum_ext;
    logic signed [15:0] sum_sat;
    logic               fire_hit;

    logic               pot_we;
    logic [ADDR_W-1:0]  pot_waddr;
    logic signed [15:0] pot_wdata;
    logic               thr_we;
    logic [ADDR_W-1:0]  thr_waddr;
    logic [7:0]         thr_wdata;

    // next_step only marks a time-step boundary; there is no leak to apply
    logic               unused_next_step;
    assign unused_next_step = next_step;

    assign clear_any = clear_act | clear_config;
    assign accept    = (state == IDLE) && dend_vld && dend_rdy;
    assign step_done = (state == IDLE) && !fire_vld && !dend_vld;

    always_comb begin
        sum_ext = {pot_rd[15], pot_rd} + {charge_q[15], charge_q};
        if (sum_ext[16] != sum_ext[15])
            sum_sat = sum_ext[16] ? 16'sh8000 : 16'sh7FFF;
        else
            sum_sat = sum_ext[15:0];
        fire_hit = (state == UPDATE) && !clear_any
                   && (sum_sat > $signed({8'b0, thr_rd}));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = UPDATE;
            UPDATE:  state_nxt = fire_hit ? EMIT : IDLE;
            EMIT:    if (fire_vld && fire_rdy) state_nxt = IDLE;
            CLEAR:   if (sweep_fin && !clear_any) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_any)
            state_nxt = CLEAR;
    end

    // An aborted UPDATE must not write back, so the clear check gates the RMW store
    always_comb begin
        pot_we    = 1'b0;
        pot_waddr = addr_q;
        pot_wdata = '0;
        if (state == CLEAR) begin
            pot_we    = 1'b1;
            pot_waddr = sweep_idx;
        end else if (state == UPDATE && !clear_any) begin
            pot_we    = 1'b1;
            pot_wdata = fire_hit ? 16'sd0 : sum_sat;
        end
    end

    always_comb begin
        thr_we    = 1'b0;
        thr_waddr = cfg_addr;
        thr_wdata = cfg_threshold;
        if (state == CLEAR && sweep_cfg) begin
            thr_we    = 1'b1;
            thr_waddr = sweep_idx;
            thr_wdata = '0;
        end else if (cfg_wr) begin
            thr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pot_we)
            pot_mem[pot_waddr] <= pot_wdata;
        if (thr_we)
            thr_mem[thr_waddr] <= thr_wdata;
        pot_rd <= pot_mem[addr_q];
        thr_rd <= thr_mem[addr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dend_rdy   <= 1'b0;
            fire_vld   <= 1'b0;
            fire_addr  <= '0;
            clear_done <= 1'b0;
            addr_q     <= '0;
            charge_q   <= '0;
            sweep_idx  <= '0;
            sweep_cfg  <= 1'b0;
            sweep_fin  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dend_rdy   <= (state_nxt == IDLE);
            clear_done <= 1'b0;

            if (accept) begin
                addr_q   <= dend_addr;
                charge_q <= enable ? dend_charge : 16'sd0;
            end

            if (clear_any) begin
                fire_vld <= 1'b0;
            end else if (fire_hit) begin
                fire_vld  <= 1'b1;
                fire_addr <= addr_q;
            end else if (fire_vld && fire_rdy) begin
                fire_vld <= 1'b0;
            end

            // A config clear arriving mid activity-sweep restarts so every threshold is zeroed
            if (state != CLEAR) begin
                sweep_idx <= '0;
                sweep_cfg <= clear_config;
                sweep_fin <= 1'b0;
            end else if (clear_config && !sweep_cfg) begin
                sweep_idx <= '0;
                sweep_cfg <= 1'b1;
                sweep_fin <= 1'b0;
            end else if (!sweep_fin) begin
                sweep_idx <= sweep_idx + 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    sweep_fin  <= 1'b1;
                    clear_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ucaspian_neuron.sv
// Directed bench for ucaspian_neuron: accumulate, strict fire, saturation, stall, clear sweeps, enable gating.
module tb_ucaspian_neuron;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear_act;
    logic              clear_config;
    logic              clear_done;
    logic              next_step;
    logic              step_done;
    logic [7:0]        cfg_addr;
    logic [7:0]        cfg_threshold;
    logic              cfg_wr;
    logic [7:0]        dend_addr;
    logic signed [15:0] dend_charge;
    logic              dend_vld;
    logic              dend_rdy;
    logic [7:0]        fire_addr;
    logic              fire_vld;
    logic              fire_rdy;

    int n_cmp = 0;
    int n_bad = 0;

    ucaspian_neuron #(.NUM_NEURONS(256), .ADDR_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .clear_act     (clear_act),
        .clear_config  (clear_config),
        .clear_done    (clear_done),
        .next_step     (next_step),
        .step_done     (step_done),
        .cfg_addr      (cfg_addr),
        .cfg_threshold (cfg_threshold),
        .cfg_wr        (cfg_wr),
        .dend_addr     (dend_addr),
        .dend_charge   (dend_charge),
        .dend_vld      (dend_vld),
        .dend_rdy      (dend_rdy),
        .fire_addr     (fire_addr),
        .fire_vld      (fire_vld),
        .fire_rdy      (fire_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] t);
        cfg_addr      = a;
        cfg_threshold = t;
        cfg_wr        = 1'b1;
        @(negedge clk);
        cfg_wr        = 1'b0;
    endtask

    task automatic flush(input logic [7:0] a, input int c, input bit exp_fire,
                         input int stall, input bit ack);
        int w;
        w = 0;
        while (!dend_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rdy_wait", dend_rdy, 1);
        dend_addr   = a;
        dend_charge = 16'(c);
        dend_vld    = 1'b1;
        next_step   = 1'b1;
        @(negedge clk);
        dend_vld    = 1'b0;
        next_step   = 1'b0;
        check("rdy_drop", dend_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        check("fire_vld", fire_vld, exp_fire);
        if (exp_fire) begin
            check("fire_addr", fire_addr, a);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_vld", fire_vld, 1);
                check("stall_addr", fire_addr, a);
                check("stall_rdy", dend_rdy, 0);
                check("stall_step_done", step_done, 0);
            end
            if (ack) begin
                fire_rdy = 1'b1;
                @(negedge clk);
                fire_rdy = 1'b0;
                check("fire_drop", fire_vld, 0);
                check("rdy_after_fire", dend_rdy, 1);
            end
        end else begin
            check("rdy_idle", dend_rdy, 1);
        end
    endtask

    task automatic do_clear(input bit cfg);
        int pulses;
        int first_k;
        int w;
        pulses  = 0;
        first_k = -1;
        if (cfg) clear_config = 1'b1;
        else     clear_act    = 1'b1;
        for (int k = 1; k <= 270; k++) begin
            @(negedge clk);
            if (k == 1) check("clear_fire_drop", fire_vld, 0);
            if (clear_done) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("clear_done_pulses", pulses, 1);
        check("clear_done_time", first_k, 257);
        check("clear_hold_rdy", dend_rdy, 0);
        clear_config = 1'b0;
        clear_act    = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!dend_rdy && w < 10);
        check("clear_exit_rdy", dend_rdy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        clear_act     = 1'b0;
        clear_config  = 1'b0;
        next_step     = 1'b0;
        cfg_addr      = '0;
        cfg_threshold = '0;
        cfg_wr        = 1'b0;
        dend_addr     = '0;
        dend_charge   = '0;
        dend_vld      = 1'b0;
        fire_rdy      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dend_rdy", dend_rdy, 0);
        check("rst_fire_vld", fire_vld, 0);
        check("rst_fire_addr", fire_addr, 0);
        check("rst_clear_done", clear_done, 0);
        reset = 1'b0;
        @(negedge clk);

        do_clear(1'b1);
        cfg_write(8'd5, 8'd10);
        cfg_write(8'd9, 8'd0);
        cfg_write(8'd3, 8'd255);

        // accumulate then fire at 12 > 10
        flush(8'd5, 6, 1'b0, 0, 1'b1);
        flush(8'd5, 6, 1'b1, 0, 1'b1);

        // strict greater-than against threshold 0
        flush(8'd9, 0, 1'b0, 0, 1'b1);
        flush(8'd9, -5, 1'b0, 0, 1'b1);
        flush(8'd9, 6, 1'b1, 0, 1'b1);

        // positive overflow saturates (wrap would go negative and not fire)
        flush(8'd3, 255, 1'b0, 0, 1'b1);
        flush(8'd3, 32767, 1'b1, 0, 1'b1);

        // negative saturation to -32768, then walk back up to 1
        flush(8'd4, -32000, 1'b0, 0, 1'b1);
        flush(8'd4, -32000, 1'b0, 0, 1'b1);
        flush(8'd4, 32767, 1'b0, 0, 1'b1);
        flush(8'd4, 1, 1'b0, 0, 1'b1);
        flush(8'd4, 1, 1'b1, 0, 1'b1);

        // fire held against backpressure for 10 cycles
        flush(8'd5, 11, 1'b1, 10, 1'b1);

        // clear_act aborts a pending fire; potentials zeroed, thresholds kept
        flush(8'd5, 6, 1'b0, 0, 1'b1);
        flush(8'd9, 1, 1'b1, 0, 1'b0);
        do_clear(1'b0);
        flush(8'd5, 6, 1'b0, 0, 1'b1);
        flush(8'd5, 5, 1'b1, 0, 1'b1);

        // disabled charge is dropped
        enable = 1'b0;
        flush(8'd7, 100, 1'b0, 0, 1'b1);
        enable = 1'b1;
        check("step_done_idle", step_done, 1);
        flush(8'd7, 0, 1'b0, 0, 1'b1);
        flush(8'd7, 1, 1'b1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ucaspian_neuron.md
Name: ucaspian_neuron

Overview:
- Consumer end of the dendrite-to-neuron flush interface. Holds a 16-bit signed potential and an 8-bit threshold for each of 256 neurons.
- For each accepted (addr, charge) flush it performs a saturating add into the potential, compares against the threshold, and on fire zeroes the potential and emits the neuron address on a fire handshake toward the axon/output stage.
- Provides step_done and activity/config clear sweeps in the same style as the rest of the core.

Parameters:
- NUM_NEURONS, 256, neuron count; addresses 0..NUM_NEURONS-1, power of two.
- ADDR_W, 8, address width, equal to log2(NUM_NEURONS).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  when low, accepted charge is treated as 0 (no fire possible)
clear_act  in  1  level; sweep all potentials to 0
clear_config  in  1  level; sweep potentials to 0 and thresholds to 0
clear_done  out  1  one-cycle pulse at end of a sweep
next_step  in  1  time-step boundary pulse
step_done  out  1  block idle, no pending fire
cfg_addr  in  8  threshold write address
cfg_threshold  in  8  unsigned threshold
cfg_wr  in  1  threshold write strobe
dend_addr  in  8  neuron address from dendrite
dend_charge  in  16  signed charge from dendrite
dend_vld  in  1  dendrite data valid
dend_rdy  out  1  block can accept
fire_addr  out  8  firing neuron address
fire_vld  out  1  fire event valid
fire_rdy  in  1  downstream accepts fire

Behaviour:
- Reset values: all registered outputs 0 (dend_rdy, fire_vld, fire_addr, clear_done); state IDLE. RAM contents are not reset; software issues clear_config or clear_act.
- Storage: potential RAM is 16x256, dual-port, 1-cycle read latency. Threshold RAM is 8x256; its write port is driven only by cfg_wr or the clear sweep.
- FSM states: IDLE, READ, UPDATE, EMIT, CLEAR.
- IDLE: dend_rdy=1. On dend_vld&&dend_rdy, latch addr and charge (0 if !enable), issue reads of potential and threshold, go to READ. dend_rdy deasserts the cycle after acceptance.
- READ: wait one cycle for RAM data, go to UPDATE.
- UPDATE:
  - sum = 17-bit signed potential + charge, saturated to [-32768, 32767].
  - fire = (sum > $signed({8'b0, threshold})), strict greater-than.
  - If fire: write 0 to the potential, load fire_addr and set fire_vld, go to EMIT.
  - Else: write sum, go to IDLE.
- EMIT: hold fire_vld and fire_addr stable until fire_rdy. In the cycle fire_vld&&fire_rdy, drop fire_vld and go to IDLE.
- Throughput: one flush per 3 cycles when no fire stall. Dendrite-in to fire_vld latency is 3 cycles.
- RMW hazard: none, since only one transaction is in flight.
- cfg_wr: accepted in any state. A write to the in-flight address after its read does not affect the current compare.
- clear_act or clear_config high, any state: abort the in-flight transaction, drop any pending fire (fire_vld=0 next cycle), dend_rdy=0, enter CLEAR.
  - Sweep index 0..255, one entry per cycle: potential<=0, plus threshold<=0 if clear_config.
  - After index 255, pulse clear_done one cycle and stay in CLEAR until both clear inputs are low, then go to IDLE.
  - A clear_config arriving during a clear_act sweep restarts the sweep at 0.
- step_done (comb): state==IDLE && !fire_vld && !dend_vld.
- next_step: has no effect on potentials (no leak); it is a marker only. A next_step coinciding with acceptance does not block acceptance.
- reset during any state: return to IDLE next cycle, drop pending fire, RAM untouched.

Test Plan:
- clear_config, then threshold[5]=10; flush (5, +6), then (5, +6) -> first: no fire, potential 6; second: sum 12>10, fire_vld with fire_addr=5 3 cycles after acceptance, potential[5]=0.
- Threshold[9]=0; flush (9, 0) -> no fire (strict >); flush (9, -5) then (9, +6) -> potential -5, then sum 1 fires.
- potential[3]=32000, threshold 255; flush (3, +32000) -> saturates to 32767 and fires. With potential[4]=-32000, flush (4, -32000) -> stored -32768, no fire.
- Fire with fire_rdy held low 10 cycles -> fire_vld and fire_addr stable, dend_rdy=0, step_done=0 throughout; release -> one handshake, back to IDLE.
- clear_act asserted while in EMIT -> fire_vld drops next cycle, 256-cycle sweep, clear_done pulses once; afterwards all potentials 0 and thresholds unchanged.
- enable=0, flush (7, +100) with threshold 0 -> no fire, potential[7] unchanged; step_done asserts once idle.
